ethernet_mii_rx_nibble_assembler: RTL and testbench

ETHERNET_MII_RX_NIBBLE_ASSEMBLER -- requirements
Module: ethernet_mii_rx_nibble_assembler

---
 rtl/ethernet_mii_rx_nibble_assembler.sv | 145 ++++++++++++++
 tb/tb_ethernet_mii_rx_nibble_assembler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_mii_rx_nibble_assembler.sv
// MII receive path: strips preamble/SFD and pairs nibbles into bytes,
// flagging frame end with length and an error summary.
module ethernet_mii_rx_nibble_assembler #(
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int LEN_WIDTH       = 11
) (
    input  logic                 MII_RX_CLK,
    input  logic                 RX_RESETN,
    input  logic [3:0]           MII_RXD,
    input  logic                 MII_RX_DV,
    input  logic                 MII_RX_ER,
    output logic [7:0]           RX_DATA,
    output logic                 RX_VALID,
    output logic                 RX_SOF,
    output logic                 RX_EOF,
    output logic                 RX_ERR,
    output logic [LEN_WIDTH-1:0] RX_LEN
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [3:0]           NIB_PRE = 4'h5;
    localparam logic [3:0]           NIB_SFD = 4'hD;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_BYTES);

    state_t               state, state_n;
    logic [3:0]           rxd_q;
    logic                 dv_q, er_q;
    logic                 phase, phase_n;
    logic [3:0]           low, low_n;
    logic [LEN_WIDTH-1:0] count, count_n;
    logic                 err, err_n;

    logic [7:0]           data_n;
    logic                 valid_n, sof_n, eof_n, err_out_n;
    logic [LEN_WIDTH-1:0] len_n;

    always_ff @(posedge MII_RX_CLK or negedge RX_RESETN) begin
        if (!RX_RESETN) begin
            rxd_q    <= '0;
            dv_q     <= 1'b0;
            er_q     <= 1'b0;
            state    <= IDLE;
            phase    <= 1'b0;
            low      <= '0;
            count    <= '0;
            err      <= 1'b0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            RX_SOF   <= 1'b0;
            RX_EOF   <= 1'b0;
            RX_ERR   <= 1'b0;
            RX_LEN   <= '0;
        end else begin
            rxd_q    <= MII_RXD;
            dv_q     <= MII_RX_DV;
            er_q     <= MII_RX_ER;
            state    <= state_n;
            phase    <= phase_n;
            low      <= low_n;
            count    <= count_n;
            err      <= err_n;
            RX_DATA  <= data_n;
            RX_VALID <= valid_n;
            RX_SOF   <= sof_n;
            RX_EOF   <= eof_n;
            RX_ERR   <= err_out_n;
            RX_LEN   <= len_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        low_n     = low;
        count_n   = count;
        err_n     = err;
        data_n    = RX_DATA;
        valid_n   = 1'b0;
        sof_n     = 1'b0;
        eof_n     = 1'b0;
        err_out_n = 1'b0;
        len_n     = RX_LEN;

        unique case (state)
            IDLE: begin
                if (dv_q) begin
                    state_n = (rxd_q == NIB_PRE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!dv_q) begin
                    state_n = IDLE;
                end else if (rxd_q == NIB_SFD) begin
                    state_n = DATA;
                    phase_n = 1'b0;
                    count_n = '0;
                    err_n   = 1'b0;
                end else if (rxd_q != NIB_PRE) begin
                    state_n = DROP;
                end
            end
            DATA: begin
                if (!dv_q) begin
                    // A pending low nibble at DV fall means an odd nibble count
                    eof_n     = 1'b1;
                    len_n     = count;
                    err_out_n = err | phase;
                    phase_n   = 1'b0;
                    state_n   = IDLE;
                end else begin
                    if (er_q) begin
                        err_n = 1'b1;
                    end
                    if (!phase) begin
                        low_n   = rxd_q;
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (count == MAX_LEN) begin
                            err_n = 1'b1;
                        end else begin
                            data_n  = {rxd_q, low};
                            valid_n = 1'b1;
                            sof_n   = (count == '0);
                            count_n = count + LEN_WIDTH'(1);
                        end
                    end
                end
            end
            DROP: begin
                if (!dv_q) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ethernet_mii_rx_nibble_assembler.sv
// Scoreboard bench: two instances (default and 4-byte limit) share the
// MII stimulus; each has its own expected-event queue and monitor.
module tb_ethernet_mii_rx_nibble_assembler;

    typedef struct packed {
        logic        eof;
        logic [7:0]  data;
        logic        sof;
        logic [10:0] len;
        logic        err;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rxd = '0;
    logic        dv = 1'b0;
    logic        er = 1'b0;

    logic [7:0]  d0_data, d1_data;
    logic        d0_valid, d0_sof, d0_eof, d0_err;
    logic        d1_valid, d1_sof, d1_eof, d1_err;
    logic [10:0] d0_len, d1_len;

    ev_t         q0[$];
    ev_t         q1[$];
    logic [7:0]  fb[$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    ethernet_mii_rx_nibble_assembler dut (
        .MII_RX_CLK(clk), .RX_RESETN(rst_n), .MII_RXD(rxd),
        .MII_RX_DV(dv), .MII_RX_ER(er), .RX_DATA(d0_data),
        .RX_VALID(d0_valid), .RX_SOF(d0_sof), .RX_EOF(d0_eof),
        .RX_ERR(d0_err), .RX_LEN(d0_len)
    );

    ethernet_mii_rx_nibble_assembler #(.MAX_FRAME_BYTES(4)) dut4 (
        .MII_RX_CLK(clk), .RX_RESETN(rst_n), .MII_RXD(rxd),
        .MII_RX_DV(dv), .MII_RX_ER(er), .RX_DATA(d1_data),
        .RX_VALID(d1_valid), .RX_SOF(d1_sof), .RX_EOF(d1_eof),
        .RX_ERR(d1_err), .RX_LEN(d1_len)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ev_t byte_ev(input logic [7:0] d, input logic s);
        ev_t e;
        e = '0;
        e.data = d;
        e.sof = s;
        return e;
    endfunction

    function automatic ev_t eof_ev(input int n, input logic e_);
        ev_t e;
        e = '0;
        e.eof = 1'b1;
        e.len = 11'(n);
        e.err = e_;
        return e;
    endfunction

    // Actual byte events carry don't-care len/err; eof events carry don't-care data/sof
    function automatic ev_t pack_act(input logic v, input logic [7:0] d,
                                     input logic s, input logic f,
                                     input logic [10:0] l, input logic e_);
        ev_t e;
        e = '0;
        e.eof = f;
        if (v) begin
            e.data = d;
            e.sof = s;
        end else begin
            e.len = l;
            e.err = e_;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (d0_valid || d0_eof) begin
            ev_t a;
            a = pack_act(d0_valid, d0_data, d0_sof, d0_eof, d0_len, d0_err);
            check("dut_valid_eof_exclusive", {31'd0, d0_valid & d0_eof}, 32'd0);
            if (q0.size() == 0) check("dut_unexpected_output", a, 32'd0);
            else check("dut_event", a, q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (d1_valid || d1_eof) begin
            ev_t a;
            a = pack_act(d1_valid, d1_data, d1_sof, d1_eof, d1_len, d1_err);
            check("dut4_valid_eof_exclusive", {31'd0, d1_valid & d1_eof}, 32'd0);
            if (q1.size() == 0) check("dut4_unexpected_output", a, 32'd0);
            else check("dut4_event", a, q1.pop_front());
        end
    end

    task automatic drive(input logic v, input logic [3:0] d, input logic e_);
        @(negedge clk);
        dv = v;
        rxd = d;
        er = e_;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic expect_frame(input int max, input logic odd, input logic er_hit,
                                inout ev_t q[$]);
        int n;
        n = fb.size();
        for (int i = 0; i < n && i < max; i++) q.push_back(byte_ev(fb[i], i == 0));
        q.push_back(eof_ev(n < max ? n : max, odd | er_hit | (n > max)));
    endtask

    // good=0 starts with 0x3 so the whole frame should be dropped
    task automatic send_frame(input logic good, input logic odd, input int er_nib);
        if (good) begin
            expect_frame(1522, odd, er_nib >= 0, q0);
            expect_frame(4, odd, er_nib >= 0, q1);
            drive(1'b1, 4'h5, 1'b0);
        end else begin
            drive(1'b1, 4'h3, 1'b0);
        end
        for (int i = 0; i < 6; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < fb.size(); i++) begin
            drive(1'b1, fb[i][3:0], er_nib == 2 * i);
            drive(1'b1, fb[i][7:4], er_nib == 2 * i + 1);
        end
        if (odd) drive(1'b1, 4'hA, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dut"}, {d0_data, d0_valid, d0_sof, d0_eof, d0_err, d0_len}, 32'd0);
        check({tag, "_dut4"}, {d1_data, d1_valid, d1_sof, d1_eof, d1_err, d1_len}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        idle(2);

        fb = '{8'h21, 8'h43};
        send_frame(1'b1, 1'b0, -1);
        idle(4);

        send_frame(1'b1, 1'b1, -1);
        idle(4);

        fb = {};
        for (int i = 0; i < 64; i++) fb.push_back(8'(i * 7 + 3));
        send_frame(1'b1, 1'b0, 1);
        idle(4);

        fb = '{8'h21, 8'h43};
        send_frame(1'b0, 1'b0, -1);
        fb = '{8'hA5, 8'h5A, 8'hFF};
        send_frame(1'b1, 1'b0, -1);
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(1'b1, 1'b0, -1);
        idle(4);

        // Reset lands mid-frame: only the bytes before it appear, no EOF
        q0.push_back(byte_ev(8'h21, 1'b1));
        q0.push_back(byte_ev(8'h43, 1'b0));
        q1.push_back(byte_ev(8'h21, 1'b1));
        q1.push_back(byte_ev(8'h43, 1'b0));
        for (int i = 0; i < 7; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        drive(1'b1, 4'h1, 1'b0);
        drive(1'b1, 4'h2, 1'b0);
        drive(1'b1, 4'h3, 1'b0);
        drive(1'b1, 4'h4, 1'b0);
        drive(1'b1, 4'h6, 1'b0);
        drive(1'b1, 4'h7, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 4'h8, 1'b0);
        drive(1'b1, 4'h9, 1'b0);
        check_outputs_zero("mid_frame_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 4'h6, 1'b0);
        idle(6);

        fb = '{8'hDE, 8'hAD};
        send_frame(1'b1, 1'b0, -1);
        idle(8);

        check("dut_queue_drained", q0.size(), 32'd0);
        check("dut4_queue_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
